reset_sequencer: RTL and testbench

- Consumes the synchronised board reset `reset_n` from the reset generator.
- Releases NB_STAGES downstream reset domains one at a time, in a fixed order, after a programmable hold time (e.g. clocking/memory first, then datapath, then video/IO).
- Raises `rst_done` once every domain is out of reset.
- Accepts a synchronous soft-reset request that replays the whole sequence without touching the board reset.

---
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: after a hold time, frees NB_STAGES reset domains one at a time, then flags rst_done.
// Optional macro RESET_SEQUENCER_CNT_EN adds a saturating soft_rst_cnt output counting accepted soft resets.
module reset_sequencer #(
  parameter int NB_STAGES   = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 soft_rst_req,
  output logic [NB_STAGES-1:0] rst_stage_n,
  output logic                 rst_done
`ifdef RESET_SEQUENCER_CNT_EN
  ,
  output logic [7:0]           soft_rst_cnt
`endif
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NB_STAGES) + 1;

  generate
    if (NB_STAGES < 1 || NB_STAGES > 8) begin : g_bad_nb_stages
      $error("reset_sequencer: NB_STAGES must be in 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("reset_sequencer: GAP_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_GAP,
    ST_DONE_WAIT,
    ST_DONE
  } state_t;

  state_t               r_state, r_state_next;
  logic [CNT_W-1:0]     r_cnt, r_cnt_next;
  logic [IDX_W-1:0]     r_idx, r_idx_next;
  logic [NB_STAGES-1:0] r_stage_n, r_stage_n_next;
  logic                 r_done, r_done_next;
  logic                 w_soft_accept;
  logic [NB_STAGES-1:0] w_idx_onehot;

  // Decode the stage index into the bit to be released next.
  generate
    for (genvar gi = 0; gi < NB_STAGES; gi++) begin : g_onehot
      assign w_idx_onehot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_stage_n <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_cnt     <= r_cnt_next;
      r_idx     <= r_idx_next;
      r_stage_n <= r_stage_n_next;
      r_done    <= r_done_next;
    end
  end

  always_comb begin
    r_state_next   = r_state;
    r_cnt_next     = r_cnt;
    r_idx_next     = r_idx;
    r_stage_n_next = r_stage_n;
    r_done_next    = r_done;
    w_soft_accept  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          r_cnt_next        = '0;
          r_stage_n_next[0] = 1'b1;
          r_idx_next        = IDX_W'(1);
          r_state_next      = (NB_STAGES == 1) ? ST_DONE_WAIT : ST_GAP;
        end else begin
          r_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          r_cnt_next     = '0;
          r_stage_n_next = r_stage_n | w_idx_onehot;
          r_idx_next     = r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NB_STAGES - 1)) begin
            r_state_next = ST_DONE_WAIT;
          end
        end else begin
          r_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE_WAIT: begin
        r_done_next  = 1'b1;
        r_state_next = ST_DONE;
      end
      ST_DONE: begin
        // Soft reset only takes effect once the sequence has fully completed.
        if (soft_rst_req) begin
          w_soft_accept  = 1'b1;
          r_stage_n_next = '0;
          r_done_next    = 1'b0;
          r_cnt_next     = '0;
          r_idx_next     = '0;
          r_state_next   = ST_HOLD;
        end
      end
      default: begin
        r_state_next = ST_HOLD;
      end
    endcase
  end

  assign rst_stage_n = r_stage_n;
  assign rst_done    = r_done;

`ifdef RESET_SEQUENCER_CNT_EN
  logic [7:0] r_soft_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_soft_cnt <= 8'd0;
    end else if (w_soft_accept && (r_soft_cnt != 8'hFF)) begin
      r_soft_cnt <= r_soft_cnt + 8'd1;
    end
  end

  assign soft_rst_cnt = r_soft_cnt;
`else
  logic w_unused_soft_accept;
  assign w_unused_soft_accept = w_soft_accept;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, minimal (1/1/1) and 8-stage (gap 2) instances.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       soft_rst_req_s1 = 1'b0;
  logic [2:0] stage_def;
  logic       done_def;
  logic [0:0] stage_s1;
  logic       done_s1;
  logic [7:0] stage_s8;
  logic       done_s8;
`ifdef RESET_SEQUENCER_CNT_EN
  logic [7:0] cnt_def;
  logic [7:0] cnt_s1;
  logic [7:0] cnt_s8;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cur_edge = 0;

  always #5 clk = ~clk;

  reset_sequencer u_def (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req),
    .rst_stage_n  (stage_def),
    .rst_done     (done_def)
`ifdef RESET_SEQUENCER_CNT_EN
    ,
    .soft_rst_cnt (cnt_def)
`endif
  );

  reset_sequencer #(.NB_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_s1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req_s1),
    .rst_stage_n  (stage_s1),
    .rst_done     (done_s1)
`ifdef RESET_SEQUENCER_CNT_EN
    ,
    .soft_rst_cnt (cnt_s1)
`endif
  );

  reset_sequencer #(.NB_STAGES(8), .HOLD_CYCLES(16), .GAP_CYCLES(2)) u_s8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .soft_rst_req (soft_rst_req),
    .rst_stage_n  (stage_s8),
    .rst_done     (done_s8)
`ifdef RESET_SEQUENCER_CNT_EN
    ,
    .soft_rst_cnt (cnt_s8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d: got %0h expected %0h", tag, cur_edge, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cur_edge++;
  endtask

  // Expected stage patterns, edges counted from the first edge after release.
  function automatic logic [2:0] exp_def(input int e);
    return {(e >= 24), (e >= 20), (e >= 16)};
  endfunction

  function automatic logic [7:0] exp_s8(input int e);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = (e >= 16 + 2 * k);
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_def_stage", 32'(stage_def), 32'h0);
    chk("rst_def_done",  32'(done_def),  32'h0);
    chk("rst_s8_stage",  32'(stage_s8),  32'h0);
    chk("rst_s1_stage",  32'(stage_s1),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cur_edge = 0;
  endtask

  // Steps n edges checking every instance; soft_rst_req is high at edges p1 and p2.
  task automatic run_check(input int n, input int p1, input int p2);
    for (int e = 1; e <= n; e++) begin
      soft_rst_req = (e == p1) || (e == p2);
      step();
      chk("def_stage", 32'(stage_def), 32'(exp_def(e)));
      chk("def_done",  32'(done_def),  32'(e >= 25));
      chk("s1_stage",  32'(stage_s1),  32'(e >= 1));
      chk("s1_done",   32'(done_s1),   32'(e >= 2));
      chk("s8_stage",  32'(stage_s8),  32'(exp_s8(e)));
      chk("s8_done",   32'(done_s8),   32'(e >= 31));
    end
    soft_rst_req = 1'b0;
  endtask

  initial begin
    // Power-on sequence
    do_reset();
    run_check(32, -1, -1);

    // Asynchronous reset between edges 21 and 22
    do_reset();
    run_check(21, -1, -1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_def_stage", 32'(stage_def), 32'h0);
    chk("async_def_done",  32'(done_def),  32'h0);
    chk("async_s8_stage",  32'(stage_s8),  32'h0);
    chk("async_s1_done",   32'(done_s1),   32'h0);
    do_reset();
    run_check(32, -1, -1);

    // Soft reset accepted in DONE, then full replay
    soft_rst_req    = 1'b1;
    soft_rst_req_s1 = 1'b1;
    step();
    chk("soft_def_stage", 32'(stage_def), 32'h0);
    chk("soft_def_done",  32'(done_def),  32'h0);
    chk("soft_s1_stage",  32'(stage_s1),  32'h0);
    chk("soft_s8_stage",  32'(stage_s8),  32'h0);
    soft_rst_req    = 1'b0;
    soft_rst_req_s1 = 1'b0;
    cur_edge = 0;
    run_check(32, -1, -1);

    // Soft reset pulses during HOLD (edge 8) and GAP (edge 18) are ignored
    do_reset();
    run_check(32, 8, 18);

`ifdef RESET_SEQUENCER_CNT_EN
    chk("cnt_init", 32'(cnt_def), 32'd0);
    soft_rst_req = 1'b1;
    step();
    chk("cnt_first", 32'(cnt_def), 32'd1);
    repeat (52) step();
    chk("cnt_three", 32'(cnt_def), 32'd3);
    repeat (26 * 257) step();
    chk("cnt_sat", 32'(cnt_def), 32'd255);
    soft_rst_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("cnt_clear", 32'(cnt_def), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
